raster_scheduler: RTL and testbench

Triangle dispatch controller in front of rasterizer_unit. Accepts transformed triangles (raster-space FP32 vertices plus colour) through a valid/ready port and buffers them in a small FIFO. It launches one rasterization at a time using the rasterizer's start/done handshake and holds the vertex operands stable for the whole rasterization. It also provides a frame-flush handshake so the display side knows when all queued geometry has reached the framebuffer.

---
 rtl/raster_pkg.sv | 34 +++
 rtl/raster_scheduler_tri_fifo.sv | 64 ++++++
 rtl/raster_scheduler.sv | 133 +++++++++++++
 tb/tb_raster_scheduler.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/raster_pkg.sv
// Shared types and constants for the triangle dispatch path (scheduler and rasterizer).
package raster_pkg;

  localparam logic [31:0] FP_ONE = 32'h3f80_0000;
  localparam int unsigned TRI_W  = 292;

  // Element [0] is x, [1] is y, [2] is z, matching a {x,y,z} concatenation.
  typedef logic [0:2][31:0] vec3_t;

  typedef struct packed {
    vec3_t      p1;
    vec3_t      p2;
    vec3_t      p3;
    logic [3:0] color;
  } tri_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_LOW,
    S_WAIT_DONE
  } sched_state_e;

  function automatic tri_t make_tri(input vec3_t a, input vec3_t b, input vec3_t c,
                                    input logic [3:0] col);
    tri_t t;
    t.p1    = a;
    t.p2    = b;
    t.p3    = c;
    t.color = col;
    return t;
  endfunction

endpackage

// File: rtl/raster_scheduler_tri_fifo.sv
// Synchronous triangle FIFO; the read register doubles as the rasterizer operand hold.
module tri_fifo
  import raster_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   areset_n,
  input  logic                   i_push,
  input  tri_t                   i_wr_data,
  input  logic                   i_pop,
  output tri_t                   o_rd_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int unsigned AW = $clog2(DEPTH);

  tri_t          r_mem [DEPTH];
  tri_t          r_rd_data;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_full    = (r_level == (AW+1)'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_rd_data = r_rd_data;
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!areset_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_rd_data <= r_mem[r_rd_ptr];
      end
      unique case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/raster_scheduler.sv
// Triangle dispatch controller: queues triangles, launches the rasterizer one at a time,
// and signals when a requested frame drain has fully completed.
module raster_scheduler
  import raster_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   areset_n,
  input  logic                   tri_valid,
  output logic                   tri_ready,
  input  logic [0:2][31:0]       tri_p1,
  input  logic [0:2][31:0]       tri_p2,
  input  logic [0:2][31:0]       tri_p3,
  input  logic [3:0]             tri_color,
  input  logic                   flush_req,
  output logic                   flush_done,
  output logic                   ras_start,
  input  logic                   ras_done,
  output logic [0:2][31:0]       ras_p1,
  output logic [0:2][31:0]       ras_p2,
  output logic [0:2][31:0]       ras_p3,
  output logic [3:0]             ras_color,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [CNT_W-1:0]       tri_count
);

  sched_state_e          r_state;
  logic                  r_start;
  logic                  r_busy;
  logic                  r_draining;
  logic                  r_flush_done;
  logic [CNT_W-1:0]      r_count;

  tri_t                  w_wr_data;
  tri_t                  w_rd_data;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_flush_fire;
  logic [$clog2(DEPTH):0] w_level;

  assign w_wr_data    = make_tri(tri_p1, tri_p2, tri_p3, tri_color);
  assign tri_ready    = !w_full && !r_draining;
  assign w_push       = tri_valid && tri_ready;
  assign w_pop        = (r_state == S_IDLE) && !w_empty && ras_done;
  assign w_flush_fire = r_draining && w_empty && (r_state == S_IDLE) && !w_pop;

  tri_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .areset_n (areset_n),
    .i_push   (w_push),
    .i_wr_data(w_wr_data),
    .i_pop    (w_pop),
    .o_rd_data(w_rd_data),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_level  (w_level)
  );

  // WAIT_LOW exists so the done level left over from the previous triangle is not
  // taken as completion of the one just launched.
  always_ff @(posedge clk) begin
    if (!areset_n) begin
      r_state <= S_IDLE;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_count <= '0;
    end else begin
      r_start <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_state <= S_LAUNCH;
            r_start <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_LAUNCH: begin
          r_state <= S_WAIT_LOW;
        end
        S_WAIT_LOW: begin
          if (!ras_done) begin
            r_state <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (ras_done) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_count <= r_count + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Completion wins over a still-high request, so a held flush_req re-arms on the
  // cycle the pulse is visible rather than stretching the pulse.
  always_ff @(posedge clk) begin
    if (!areset_n) begin
      r_draining   <= 1'b0;
      r_flush_done <= 1'b0;
    end else begin
      r_flush_done <= w_flush_fire;
      if (w_flush_fire) begin
        r_draining <= 1'b0;
      end else if (flush_req) begin
        r_draining <= 1'b1;
      end
    end
  end

  assign ras_start  = r_start;
  assign busy       = r_busy;
  assign flush_done = r_flush_done;
  assign tri_count  = r_count;
  assign fifo_level = w_level;
  assign ras_p1     = w_rd_data.p1;
  assign ras_p2     = w_rd_data.p2;
  assign ras_p3     = w_rd_data.p3;
  assign ras_color  = w_rd_data.color;

endmodule

// File: tb/tb_raster_scheduler.sv
// Bench for raster_scheduler: transaction-level scheduler model, rasterizer responder,
// and directed scenarios with literal expectations.
module tb_raster_scheduler;
  import raster_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             areset_n;
  logic             tri_valid;
  logic             tri_ready;
  vec3_t            tri_p1, tri_p2, tri_p3;
  logic [3:0]       tri_color;
  logic             flush_req;
  logic             flush_done;
  logic             ras_start;
  logic             ras_done;
  vec3_t            ras_p1, ras_p2, ras_p3;
  logic [3:0]       ras_color;
  logic             busy;
  logic [LW-1:0]    fifo_level;
  logic [CNT_W-1:0] tri_count;

  raster_scheduler #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .areset_n  (areset_n),
    .tri_valid (tri_valid),
    .tri_ready (tri_ready),
    .tri_p1    (tri_p1),
    .tri_p2    (tri_p2),
    .tri_p3    (tri_p3),
    .tri_color (tri_color),
    .flush_req (flush_req),
    .flush_done(flush_done),
    .ras_start (ras_start),
    .ras_done  (ras_done),
    .ras_p1    (ras_p1),
    .ras_p2    (ras_p2),
    .ras_p3    (ras_p3),
    .ras_color (ras_color),
    .busy      (busy),
    .fifo_level(fifo_level),
    .tri_count (tri_count)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Rasterizer responder: done falls rz_drop cycles after start, stays low rz_low cycles.
  int  rz_drop = 1;
  int  rz_low  = 6;
  int  rz_cnt  = 0;
  bit  rz_active = 1'b0;

  always @(negedge clk) begin
    if (!areset_n) begin
      rz_active = 1'b0;
      ras_done  = 1'b1;
    end else begin
      if (ras_start) begin
        rz_active = 1'b1;
        rz_cnt    = 0;
      end else if (rz_active) begin
        rz_cnt++;
        if (rz_cnt >= rz_drop + rz_low) rz_active = 1'b0;
      end
      ras_done = !(rz_active && rz_cnt >= rz_drop);
    end
  end

  // Scheduler model: a queue of waiting triangles plus one owned triangle whose
  // completion is the first done-high seen after a done-low following the start cycle.
  tri_t        m_q[$];
  tri_t        m_ops;
  bit          m_owned, m_low_seen, m_drain, m_fdone, m_live;
  int          m_age;
  int unsigned m_count;

  always @(posedge clk) begin
    bit accept, take, fin;
    if (!areset_n) begin
      m_q.delete();
      m_ops      = '0;
      m_owned    = 1'b0;
      m_low_seen = 1'b0;
      m_drain    = 1'b0;
      m_fdone    = 1'b0;
      m_age      = 0;
      m_count    = 0;
      m_live     = 1'b1;
    end else begin
      accept = tri_valid && (m_q.size() < DEPTH) && !m_drain;
      take   = !m_owned && (m_q.size() != 0) && ras_done;
      fin    = m_drain && (m_q.size() == 0) && !m_owned && !take;
      if (m_owned) begin
        if (m_age == 1) m_age = 2;
        else if (!m_low_seen) m_low_seen = !ras_done;
        else if (ras_done) begin
          m_owned = 1'b0;
          m_count++;
        end
      end
      if (take) begin
        m_ops      = m_q.pop_front();
        m_owned    = 1'b1;
        m_age      = 1;
        m_low_seen = 1'b0;
      end
      if (accept) m_q.push_back(make_tri(tri_p1, tri_p2, tri_p3, tri_color));
      m_fdone = fin;
      if (fin) m_drain = 1'b0;
      else if (flush_req) m_drain = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("tri_ready",  tri_ready,  (m_q.size() < DEPTH) && !m_drain);
      check("fifo_level", fifo_level, m_q.size());
      check("busy",       busy,       m_owned);
      check("ras_start",  ras_start,  m_owned && (m_age == 1));
      check("ras_p1",     ras_p1,     m_ops.p1);
      check("ras_p2",     ras_p2,     m_ops.p2);
      check("ras_p3",     ras_p3,     m_ops.p3);
      check("ras_color",  ras_color,  m_ops.color);
      check("tri_count",  tri_count,  m_count[CNT_W-1:0]);
      check("flush_done", flush_done, m_fdone);
    end
  end

  int         n_starts = 0;
  int         n_fdone  = 0;
  logic [3:0] last_color = '0;
  always @(posedge clk) begin
    if (ras_start) begin
      n_starts++;
      last_color = ras_color;
    end
    if (flush_done) n_fdone++;
  end

  task automatic push(input tri_t t);
    int n = 0;
    tri_p1    = t.p1;
    tri_p2    = t.p2;
    tri_p3    = t.p3;
    tri_color = t.color;
    tri_valid = 1'b1;
    while (!tri_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("push_wait", n < 2000, 1'b1);
    @(negedge clk);
    tri_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || fifo_level != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle_wait"}, n < 5000, 1'b1);
  endtask

  task automatic wait_flush(input string tag, output int n);
    n = 0;
    while (!flush_done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_flush_wait"}, n < 5000, 1'b1);
  endtask

  function automatic tri_t gen_tri(input int id);
    vec3_t a, b, c;
    a = {32'(id * 16 + 1), 32'(id * 16 + 2), 32'(id * 16 + 3)};
    b = {32'(id * 16 + 4), 32'(id * 16 + 5), 32'(id * 16 + 6)};
    c = {32'(id * 16 + 7), 32'(id * 16 + 8), 32'(id * 16 + 9)};
    return make_tri(a, b, c, 4'(id));
  endfunction

  localparam logic [95:0] T0_P1 = 96'h41200000_41200000_40000000;
  localparam logic [95:0] T0_P2 = 96'h42480000_41200000_40000000;
  localparam logic [95:0] T0_P3 = 96'h41f00000_42200000_40000000;

  initial begin
    int n;
    areset_n  = 1'b0;
    tri_valid = 1'b0;
    flush_req = 1'b0;
    ras_done  = 1'b1;
    tri_p1    = '0;
    tri_p2    = '0;
    tri_p3    = '0;
    tri_color = '0;
    repeat (3) @(negedge clk);
    check("rst_count", tri_count, 0);
    check("rst_level", fifo_level, 0);
    check("rst_busy",  busy, 0);
    check("rst_start", ras_start, 0);
    check("rst_ops",   ras_p1, 0);
    areset_n = 1'b1;

    // Single triangle with operand hold
    rz_drop = 1; rz_low = 6;
    push(make_tri(T0_P1, T0_P2, T0_P3, 4'hf));
    check("t1_no_early_start", ras_start, 0);
    @(negedge clk);
    check("t1_start", ras_start, 1);
    check("t1_p1", ras_p1, T0_P1);
    check("t1_p2", ras_p2, T0_P2);
    check("t1_p3", ras_p3, T0_P3);
    check("t1_color", ras_color, 4'hf);
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
      check("t1_hold_p1", ras_p1, T0_P1);
      check("t1_hold_p3", ras_p3, T0_P3);
    end
    check("t1_count", tri_count, 1);
    check("t1_busy_fall", busy, 0);

    // Done-level filtering: slow drop, then very short low
    rz_drop = 4; rz_low = 5;
    push(gen_tri(1));
    wait_idle("slow");
    check("slow_count", tri_count, 2);
    rz_drop = 1; rz_low = 1;
    push(gen_tri(2));
    wait_idle("fast");
    check("fast_count", tri_count, 3);

    // FIFO full while the rasterizer is slow
    rz_drop = 1; rz_low = 100;
    for (int i = 1; i <= 5; i++) push(gen_tri(i));
    check("full_level", fifo_level, 4);
    check("full_ready", tri_ready, 0);
    wait_idle("full");
    check("full_count", tri_count, 8);
    check("full_last_color", last_color, 4'd5);

    // Flush with three triangles queued
    rz_drop = 1; rz_low = 10;
    n_fdone = 0;
    for (int i = 6; i <= 8; i++) push(gen_tri(i));
    flush_req = 1'b1;
    @(negedge clk);
    check("flush_ready_low", tri_ready, 0);
    wait_flush("flush3", n);
    check("flush3_count", tri_count, 11);
    check("flush3_level", fifo_level, 0);
    flush_req = 1'b0;
    repeat (5) @(negedge clk);
    check("flush3_once", n_fdone, 1);
    check("flush3_ready_back", tri_ready, 1);

    // Flush with nothing queued
    flush_req = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!flush_done && n < 50);
    check("flush_empty_latency", n, 2);
    flush_req = 1'b0;
    repeat (3) @(negedge clk);

    // Flush and push in the same cycle
    tri_p1 = gen_tri(9).p1; tri_p2 = gen_tri(9).p2; tri_p3 = gen_tri(9).p3;
    tri_color = 4'd9;
    check("flushpush_ready", tri_ready, 1);
    tri_valid = 1'b1;
    flush_req = 1'b1;
    @(negedge clk);
    tri_valid = 1'b0;
    wait_flush("flushpush", n);
    check("flushpush_count", tri_count, 12);
    check("flushpush_color", ras_color, 4'd9);
    flush_req = 1'b0;
    repeat (3) @(negedge clk);

    // Reset while waiting for done with two queued
    rz_drop = 1; rz_low = 100;
    for (int i = 10; i <= 12; i++) push(gen_tri(i));
    repeat (4) @(negedge clk);
    check("mid_level", fifo_level, 2);
    check("mid_busy", busy, 1);
    areset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_count", tri_count, 0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_busy",  busy, 0);
    check("mid_rst_start", ras_start, 0);
    check("mid_rst_ops",   ras_p1, 0);
    check("mid_rst_fdone", flush_done, 0);
    @(negedge clk);
    areset_n = 1'b1;
    n_starts = 0;
    repeat (20) @(negedge clk);
    check("mid_no_start", n_starts, 0);
    rz_low = 4;
    push(gen_tri(13));
    wait_idle("post_rst");
    check("post_rst_count", tri_count, 1);
    check("post_rst_starts", n_starts, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    tests_failed++;
    $display("FAIL watchdog: simulation did not complete, expected finish before t=500000");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1);
  end

endmodule
